// File: rtl/password_box_ctrl_pkg.sv
// Shared definitions for the switch-code safe controller: state encoding,
// status widths and the default code loaded at reset.
package password_box_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPEN    = 2'd1,
        ST_CHG_ARM = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_e;

    localparam int         FAIL_W            = 2;
    localparam int         DEFAULT_CODE_W    = 4;
    localparam logic [3:0] DEFAULT_INIT_CODE = 4'b1010;

endpackage

// File: rtl/password_box_ctrl_if.sv
// Pulse/status bundle between the debounce stage, the safe controller and the LED driver.
interface password_box_ctrl_if
    import password_box_ctrl_pkg::*;
#(
    parameter int CODE_W = DEFAULT_CODE_W
);
    logic [CODE_W-1:0] code_in;
    logic              try_pulse;
    logic              chg_pulse;
    logic              open;
    logic              alarm;
    logic              chg_armed;
    logic [FAIL_W-1:0] fail_cnt;

    modport master (
        output code_in, try_pulse, chg_pulse,
        input  open, alarm, chg_armed, fail_cnt
    );

    modport slave (
        input  code_in, try_pulse, chg_pulse,
        output open, alarm, chg_armed, fail_cnt
    );
endinterface

// File: rtl/password_box_ctrl_lockout_timer.sv
// Down-counter for the lockout window: load, decrement while enabled, done at zero.
module password_box_ctrl_lockout_timer #(
    parameter int             CNT_W    = 26,
    parameter logic [CNT_W-1:0] LOAD_VAL = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);
    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);
endmodule

// File: rtl/password_box_ctrl.sv
// Safe sequencing controller: unlock attempts, failure counting, timed lockout
// and the arm-then-commit code change. LED polarity is handled by the board top.
module password_box_ctrl
    import password_box_ctrl_pkg::*;
#(
    parameter int              CODE_W      = DEFAULT_CODE_W,
    parameter logic [CODE_W-1:0] INIT_CODE   = DEFAULT_INIT_CODE,
    parameter int              MAX_FAIL    = 3,
    parameter int              LOCK_CYCLES = 50_000_000,
    parameter int              CNT_W       = 26
) (
    input logic                clk,
    input logic                rst,
    password_box_ctrl_if.slave bus
);
    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [FAIL_W-1:0] fail_q, fail_d, fail_inc;
    logic              open_q, alarm_q, armed_q;
    logic              open_d, alarm_d, armed_d;
    logic              timer_load, timer_en, timer_done;

    assign fail_inc = fail_q + 1'b1;
    assign timer_en = (state_q == ST_LOCKOUT);

    password_box_ctrl_lockout_timer #(
        .CNT_W    (CNT_W),
        .LOAD_VAL (CNT_W'(LOCK_CYCLES - 1))
    ) u_lockout_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .en   (timer_en),
        .done (timer_done)
    );

    // NOTE: the stored code is a plain register, so reset can and must restore it to INIT_CODE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLOSED;
            code_q  <= INIT_CODE;
            fail_q  <= '0;
            open_q  <= 1'b0;
            alarm_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            fail_q  <= fail_d;
            open_q  <= open_d;
            alarm_q <= alarm_d;
            armed_q <= armed_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        fail_d     = fail_q;
        timer_load = 1'b0;
        // try_pulse is tested first in every state, so it wins over a coincident chg_pulse.
        case (state_q)
            ST_CLOSED: begin
                if (bus.try_pulse) begin
                    if (bus.code_in == code_q) begin
                        state_d = ST_OPEN;
                        fail_d  = '0;
                    end else begin
                        fail_d = fail_inc;
                        if (fail_inc == FAIL_W'(MAX_FAIL)) begin
                            state_d    = ST_LOCKOUT;
                            timer_load = 1'b1;
                        end
                    end
                end
            end
            ST_OPEN: begin
                if (bus.try_pulse)      state_d = ST_CLOSED;
                else if (bus.chg_pulse) state_d = ST_CHG_ARM;
            end
            ST_CHG_ARM: begin
                if (bus.try_pulse) begin
                    state_d = ST_OPEN;
                end else if (bus.chg_pulse) begin
                    code_d  = bus.code_in;
                    state_d = ST_OPEN;
                end
            end
            ST_LOCKOUT: begin
                if (timer_done) begin
                    state_d = ST_CLOSED;
                    fail_d  = '0;
                end
            end
            default: state_d = ST_CLOSED;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        open_d  = (state_d == ST_OPEN) || (state_d == ST_CHG_ARM);
        armed_d = (state_d == ST_CHG_ARM);
        alarm_d = (state_d == ST_LOCKOUT);
    end

    assign bus.open      = open_q;
    assign bus.alarm     = alarm_q;
    assign bus.chg_armed = armed_q;
    assign bus.fail_cnt  = fail_q;
endmodule

// File: tb/tb_password_box_ctrl.sv
// Directed bench for password_box_ctrl with an 8-cycle lockout and code 1010 after reset.
module tb_password_box_ctrl;
    import password_box_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    password_box_ctrl_if #(.CODE_W(4)) bus ();

    password_box_ctrl #(
        .CODE_W      (4),
        .INIT_CODE   (DEFAULT_INIT_CODE),
        .MAX_FAIL    (3),
        .LOCK_CYCLES (8),
        .CNT_W       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // One-cycle pulse driven from a falling edge; returns on the next falling edge,
    // by which time the outputs reflect the sampled pulse.
    task automatic pulse(input logic t, input logic c, input logic [3:0] code);
        @(negedge clk);
        bus.try_pulse = t;
        bus.chg_pulse = c;
        bus.code_in   = code;
        @(negedge clk);
        bus.try_pulse = 1'b0;
        bus.chg_pulse = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic o, input logic a, input logic ar,
                              input logic [1:0] f);
        if ({bus.open, bus.alarm, bus.chg_armed, bus.fail_cnt} !== {o, a, ar, f}) begin
            n_fail++;
            $display("FAIL %s: got open=%b alarm=%b armed=%b fail=%0d, exp open=%b alarm=%b armed=%b fail=%0d",
                     tag, bus.open, bus.alarm, bus.chg_armed, bus.fail_cnt, o, a, ar, f);
        end
        n_checks++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expect_out("reset_state", 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic test_unlock();
        pulse(1'b1, 1'b0, 4'b1010);
        expect_out("unlock_ok", 1'b1, 1'b0, 1'b0, 2'd0);
        pulse(1'b1, 1'b0, 4'b0000);
        expect_out("manual_relock", 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic test_lockout();
        int alarm_cycles = 0;
        pulse(1'b1, 1'b0, 4'b0001);
        expect_out("fail_1", 1'b0, 1'b0, 1'b0, 2'd1);
        pulse(1'b1, 1'b0, 4'b0001);
        expect_out("fail_2", 1'b0, 1'b0, 1'b0, 2'd2);
        pulse(1'b1, 1'b0, 4'b0001);
        expect_out("lockout_entry", 1'b0, 1'b1, 1'b0, 2'd3);
        // Count alarm cycles; a correct-code try is injected mid-lockout and must be ignored.
        for (int guard = 0; guard < 20 && bus.alarm === 1'b1; guard++) begin
            alarm_cycles++;
            bus.try_pulse = (guard == 2);
            bus.code_in   = 4'b1010;
            @(negedge clk);
            bus.try_pulse = 1'b0;
        end
        if (alarm_cycles != 8) begin
            n_fail++;
            $display("FAIL alarm_duration: got %0d cycles, exp 8", alarm_cycles);
        end
        n_checks++;
        expect_out("lockout_exit", 1'b0, 1'b0, 1'b0, 2'd0);
        pulse(1'b1, 1'b0, 4'b1010);
        expect_out("unlock_after_lockout", 1'b1, 1'b0, 1'b0, 2'd0);
        pulse(1'b1, 1'b0, 4'b0000);
    endtask

    task automatic test_change_code();
        pulse(1'b1, 1'b0, 4'b1010);
        pulse(1'b0, 1'b1, 4'b0000);
        expect_out("chg_arm", 1'b1, 1'b0, 1'b1, 2'd0);
        pulse(1'b0, 1'b1, 4'b0110);
        expect_out("chg_commit", 1'b1, 1'b0, 1'b0, 2'd0);
        pulse(1'b1, 1'b0, 4'b0000);
        expect_out("relock_after_chg", 1'b0, 1'b0, 1'b0, 2'd0);
        pulse(1'b1, 1'b0, 4'b1010);
        expect_out("old_code_fails", 1'b0, 1'b0, 1'b0, 2'd1);
        pulse(1'b1, 1'b0, 4'b0110);
        expect_out("new_code_opens", 1'b1, 1'b0, 1'b0, 2'd0);
        pulse(1'b1, 1'b0, 4'b0000);
    endtask

    task automatic test_abort_and_simultaneous();
        pulse(1'b1, 1'b0, 4'b0110);
        pulse(1'b0, 1'b1, 4'b0000);
        pulse(1'b1, 1'b0, 4'b1111);
        expect_out("chg_abort", 1'b1, 1'b0, 1'b0, 2'd0);
        pulse(1'b1, 1'b0, 4'b0000);
        pulse(1'b1, 1'b0, 4'b0110);
        expect_out("code_kept_after_abort", 1'b1, 1'b0, 1'b0, 2'd0);
        pulse(1'b1, 1'b1, 4'b0011);
        expect_out("try_beats_chg_in_open", 1'b0, 1'b0, 1'b0, 2'd0);
        pulse(1'b1, 1'b0, 4'b0110);
        expect_out("reopen_after_sim", 1'b1, 1'b0, 1'b0, 2'd0);
        pulse(1'b1, 1'b0, 4'b0000);
    endtask

    task automatic test_reset_midway();
        // Code is 0110 here, so 1010 opening afterwards proves reset restored the code.
        repeat (3) pulse(1'b1, 1'b0, 4'b0001);
        expect_out("lockout_before_rst", 1'b0, 1'b1, 1'b0, 2'd3);
        rst = 1'b1;
        @(negedge clk);
        expect_out("rst_mid_lockout", 1'b0, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;
        pulse(1'b1, 1'b0, 4'b1010);
        expect_out("code_restored", 1'b1, 1'b0, 1'b0, 2'd0);
        pulse(1'b0, 1'b1, 4'b0000);
        expect_out("armed_before_rst", 1'b1, 1'b0, 1'b1, 2'd0);
        rst = 1'b1;
        @(negedge clk);
        expect_out("rst_mid_chg", 1'b0, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;
        pulse(1'b1, 1'b0, 4'b1010);
        expect_out("open_after_chg_rst", 1'b1, 1'b0, 1'b0, 2'd0);
        pulse(1'b1, 1'b0, 4'b0000);
    endtask

    task automatic test_chg_while_closed();
        pulse(1'b1, 1'b0, 4'b0001);
        expect_out("closed_fail", 1'b0, 1'b0, 1'b0, 2'd1);
        pulse(1'b0, 1'b1, 4'b0011);
        expect_out("chg_ignored_closed", 1'b0, 1'b0, 1'b0, 2'd1);
        pulse(1'b1, 1'b0, 4'b1010);
        expect_out("open_after_ignored_chg", 1'b1, 1'b0, 1'b0, 2'd0);
        pulse(1'b1, 1'b0, 4'b0000);
    endtask

    initial begin
        bus.code_in   = 4'b0000;
        bus.try_pulse = 1'b0;
        bus.chg_pulse = 1'b0;
        test_reset();
        test_unlock();
        test_lockout();
        test_change_code();
        test_abort_and_simultaneous();
        test_reset_midway();
        test_chg_while_closed();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within 100000 time units");
        $fatal(1, "timeout");
    end
endmodule
